// File: rtl/multi_synch_unit.sv
// Per-slot outstanding-command tracker for DMA transactions.
// Raises busy, completion pulses and a sticky counter error.
`ifndef MCHAN_LEN_WIDTH
`define MCHAN_LEN_WIDTH 6
`endif

module multi_synch_unit #(
   parameter int NB_TRANS        = 4,
   parameter int TRANS_SID_WIDTH = 2,
   parameter int MCHAN_LEN_WIDTH = `MCHAN_LEN_WIDTH,
   parameter int CNT_WIDTH       = MCHAN_LEN_WIDTH + 1
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,

   input  logic                       mchan_tx_req_i,
   input  logic                       mchan_tx_gnt_i,
   input  logic [TRANS_SID_WIDTH-1:0] mchan_tx_sid_i,
   input  logic [MCHAN_LEN_WIDTH-1:0] mchan_tx_cmd_nb_i,

   input  logic                       mchan_rx_req_i,
   input  logic                       mchan_rx_gnt_i,
   input  logic [TRANS_SID_WIDTH-1:0] mchan_rx_sid_i,
   input  logic [MCHAN_LEN_WIDTH-1:0] mchan_rx_cmd_nb_i,

   input  logic                       ext_tx_synch_req_i,
   input  logic [TRANS_SID_WIDTH-1:0] ext_tx_synch_sid_i,
   input  logic                       ext_rx_synch_req_i,
   input  logic [TRANS_SID_WIDTH-1:0] ext_rx_synch_sid_i,
   input  logic                       tcdm_tx_synch_req_i,
   input  logic [TRANS_SID_WIDTH-1:0] tcdm_tx_synch_sid_i,
   input  logic                       tcdm_rx_synch_req_i,
   input  logic [TRANS_SID_WIDTH-1:0] tcdm_rx_synch_sid_i,

   input  logic                       trans_clr_i,
   input  logic [TRANS_SID_WIDTH-1:0] trans_clr_sid_i,

   output logic [NB_TRANS-1:0]        trans_status_o,
   output logic [NB_TRANS-1:0]        term_sig_o,
   output logic                       term_evt_o,

   output logic                       err_o,
   output logic [TRANS_SID_WIDTH-1:0] err_sid_o,
   input  logic                       err_clr_i
);

   // add amount holds the sum of both enqueues
   localparam int AW = MCHAN_LEN_WIDTH + 1;
   // signed working width wide enough for cnt + add with a sign bit
   localparam int SW = ((CNT_WIDTH > AW) ? CNT_WIDTH : AW) + 2;

   logic [CNT_WIDTH-1:0] tcdm_cnt [NB_TRANS];
   logic [CNT_WIDTH-1:0] ext_cnt  [NB_TRANS];
   logic [CNT_WIDTH:0]   tcdm_res [NB_TRANS];
   logic [CNT_WIDTH:0]   ext_res  [NB_TRANS];
   logic [AW-1:0]        add_amt  [NB_TRANS];
   logic [1:0]           tcdm_sub [NB_TRANS];
   logic [1:0]           ext_sub  [NB_TRANS];

   logic [NB_TRANS-1:0]  pending;
   logic [NB_TRANS-1:0]  pend_q;
   logic [NB_TRANS-1:0]  clr_hit;
   logic [NB_TRANS-1:0]  slot_err;

   logic                       tx_fire;
   logic                       rx_fire;
   logic                       any_err;
   logic [TRANS_SID_WIDTH-1:0] first_err;
   logic                       err_q;
   logic [TRANS_SID_WIDTH-1:0] err_sid_q;

   // returns {error, clamped/saturated counter}
   function automatic logic [CNT_WIDTH:0] upd(
      input logic [CNT_WIDTH-1:0] cnt,
      input logic [AW-1:0]        add,
      input logic [1:0]           sub
   );
      logic signed [SW-1:0] v;
      logic signed [SW-1:0] vmax;
      v    = $signed(SW'(cnt)) + $signed(SW'(add)) - $signed(SW'(sub));
      vmax = $signed(SW'({CNT_WIDTH{1'b1}}));
      if (v < 0)
         upd = {1'b1, {CNT_WIDTH{1'b0}}};
      else if (v > vmax)
         upd = {1'b1, {CNT_WIDTH{1'b1}}};
      else
         upd = {1'b0, v[CNT_WIDTH-1:0]};
   endfunction

   assign tx_fire = mchan_tx_req_i & mchan_tx_gnt_i;
   assign rx_fire = mchan_rx_req_i & mchan_rx_gnt_i;

   // combine every add and release of a slot into one net update
   always_comb begin
      for (int s = 0; s < NB_TRANS; s++) begin
         add_amt[s]  = '0;
         tcdm_sub[s] = '0;
         ext_sub[s]  = '0;
         if (tx_fire && mchan_tx_sid_i == TRANS_SID_WIDTH'(s))
            add_amt[s] = add_amt[s] + AW'(mchan_tx_cmd_nb_i);
         if (rx_fire && mchan_rx_sid_i == TRANS_SID_WIDTH'(s))
            add_amt[s] = add_amt[s] + AW'(mchan_rx_cmd_nb_i);
         if (tcdm_tx_synch_req_i && tcdm_tx_synch_sid_i == TRANS_SID_WIDTH'(s))
            tcdm_sub[s] = tcdm_sub[s] + 2'd1;
         if (tcdm_rx_synch_req_i && tcdm_rx_synch_sid_i == TRANS_SID_WIDTH'(s))
            tcdm_sub[s] = tcdm_sub[s] + 2'd1;
         if (ext_tx_synch_req_i && ext_tx_synch_sid_i == TRANS_SID_WIDTH'(s))
            ext_sub[s] = ext_sub[s] + 2'd1;
         if (ext_rx_synch_req_i && ext_rx_synch_sid_i == TRANS_SID_WIDTH'(s))
            ext_sub[s] = ext_sub[s] + 2'd1;
         tcdm_res[s] = upd(tcdm_cnt[s], add_amt[s], tcdm_sub[s]);
         ext_res[s]  = upd(ext_cnt[s], add_amt[s], ext_sub[s]);
         clr_hit[s]  = trans_clr_i && trans_clr_sid_i == TRANS_SID_WIDTH'(s);
         slot_err[s] = !clr_hit[s] &&
                       (tcdm_res[s][CNT_WIDTH] || ext_res[s][CNT_WIDTH]);
         pending[s]  = (tcdm_cnt[s] != '0) || (ext_cnt[s] != '0);
      end
   end

   // lowest failing slot wins the error report
   always_comb begin
      any_err   = |slot_err;
      first_err = '0;
      for (int s = NB_TRANS - 1; s >= 0; s--) begin
         if (slot_err[s])
            first_err = TRANS_SID_WIDTH'(s);
      end
   end

   // per-slot counters and delayed pending; a clear overrides all updates
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int s = 0; s < NB_TRANS; s++) begin
            tcdm_cnt[s] <= '0;
            ext_cnt[s]  <= '0;
         end
         pend_q <= '0;
      end else begin
         for (int s = 0; s < NB_TRANS; s++) begin
            if (clr_hit[s]) begin
               tcdm_cnt[s] <= '0;
               ext_cnt[s]  <= '0;
               pend_q[s]   <= 1'b0;
            end else begin
               tcdm_cnt[s] <= tcdm_res[s][CNT_WIDTH-1:0];
               ext_cnt[s]  <= ext_res[s][CNT_WIDTH-1:0];
               pend_q[s]   <= pending[s];
            end
         end
      end
   end

   // sticky error; a new error takes precedence over a clear
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_q     <= 1'b0;
         err_sid_q <= '0;
      end else if (any_err) begin
         err_q <= 1'b1;
         if (!err_q || err_clr_i)
            err_sid_q <= first_err;
      end else if (err_clr_i) begin
         err_q     <= 1'b0;
         err_sid_q <= '0;
      end
   end

   assign term_sig_o     = ~pending & pend_q;
   assign trans_status_o = pending | pend_q;
   assign term_evt_o     = |term_sig_o;
   assign err_o          = err_q;
   assign err_sid_o      = err_sid_q;

endmodule

// File: tb/tb_multi_synch_unit.sv
// Directed bench for multi_synch_unit.
// Completion pulses are checked through an expected-pulse queue.
module tb_multi_synch_unit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tx_req, tx_gnt, rx_req, rx_gnt;
   logic [1:0] tx_sid, rx_sid;
   logic [5:0] tx_nb, rx_nb;
   logic       etx_req, erx_req, ttx_req, trx_req;
   logic [1:0] etx_sid, erx_sid, ttx_sid, trx_sid;
   logic       clr, err_clr;
   logic [1:0] clr_sid;
   logic [3:0] status, term;
   logic       evt, err;
   logic [1:0] err_sid;

   int checks = 0;
   int failures = 0;
   logic [3:0] exp_q[$];
   logic [3:0] mon_exp;

   multi_synch_unit dut (
      .clk_i(clk), .rst_ni(rst_n),
      .mchan_tx_req_i(tx_req), .mchan_tx_gnt_i(tx_gnt),
      .mchan_tx_sid_i(tx_sid), .mchan_tx_cmd_nb_i(tx_nb),
      .mchan_rx_req_i(rx_req), .mchan_rx_gnt_i(rx_gnt),
      .mchan_rx_sid_i(rx_sid), .mchan_rx_cmd_nb_i(rx_nb),
      .ext_tx_synch_req_i(etx_req), .ext_tx_synch_sid_i(etx_sid),
      .ext_rx_synch_req_i(erx_req), .ext_rx_synch_sid_i(erx_sid),
      .tcdm_tx_synch_req_i(ttx_req), .tcdm_tx_synch_sid_i(ttx_sid),
      .tcdm_rx_synch_req_i(trx_req), .tcdm_rx_synch_sid_i(trx_sid),
      .trans_clr_i(clr), .trans_clr_sid_i(clr_sid),
      .trans_status_o(status), .term_sig_o(term), .term_evt_o(evt),
      .err_o(err), .err_sid_o(err_sid), .err_clr_i(err_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // monitor: every completion pulse must match the next queued vector
   always @(negedge clk) begin
      if (evt === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_term actual=%b required=none", term);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("term_vec", 32'(term), 32'(mon_exp));
         end
      end
   end

   task automatic idle();
      tx_req = 0; tx_gnt = 0; tx_sid = 0; tx_nb = 0;
      rx_req = 0; rx_gnt = 0; rx_sid = 0; rx_nb = 0;
      etx_req = 0; etx_sid = 0; erx_req = 0; erx_sid = 0;
      ttx_req = 0; ttx_sid = 0; trx_req = 0; trx_sid = 0;
      clr = 0; clr_sid = 0; err_clr = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic tx(input logic [1:0] s, input logic [5:0] n);
      tx_req = 1; tx_gnt = 1; tx_sid = s; tx_nb = n;
   endtask

   task automatic rx(input logic [1:0] s, input logic [5:0] n);
      rx_req = 1; rx_gnt = 1; rx_sid = s; rx_nb = n;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      idle();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_status", 32'(status), 0);
      chk("rst_term", 32'(term), 0);
      chk("rst_evt", 32'(evt), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_err_sid", 32'(err_sid), 0);
      rst_n = 1;
      tick();

      // request without grant must not enqueue
      tx_req = 1; tx_sid = 1; tx_nb = 3;
      tick();
      chk("no_gnt_status", 32'(status), 0);

      // single slot, three commands
      tx(1, 3);
      tick();
      chk("a_busy", 32'(status), 32'h2);
      for (int i = 0; i < 3; i++) begin
         ttx_req = 1; ttx_sid = 1; etx_req = 1; etx_sid = 1;
         if (i == 2) exp_q.push_back(4'b0010);
         tick();
         if (i < 2) chk("a_no_term", 32'(term), 0);
         chk("a_status", 32'(status), 32'h2);
      end
      chk("a_term", 32'(term), 32'h2);
      tick();
      chk("a_term_off", 32'(term), 0);
      chk("a_status_off", 32'(status), 0);

      // combined update: tcdm=2, ext=3
      tx(0, 2); rx(0, 1); trx_req = 1; trx_sid = 0;
      tick();
      chk("b_busy", 32'(status), 32'h1);
      repeat (2) begin
         ttx_req = 1; ttx_sid = 0; etx_req = 1; etx_sid = 0;
         tick();
      end
      chk("b_still_busy", 32'(status), 32'h1);
      chk("b_no_term", 32'(term), 0);
      erx_req = 1; erx_sid = 0;
      exp_q.push_back(4'b0001);
      tick();
      chk("b_term", 32'(term), 32'h1);
      chk("b_no_err", 32'(err), 0);
      tick();

      // independent slots 2 and 3
      tx(2, 5); rx(3, 1);
      tick();
      chk("c_busy", 32'(status), 32'hC);
      ttx_req = 1; ttx_sid = 3; erx_req = 1; erx_sid = 3;
      exp_q.push_back(4'b1000);
      tick();
      chk("c_term", 32'(term), 32'h8);
      chk("c_status", 32'(status), 32'hC);
      tick();
      chk("c_term_off", 32'(term), 0);
      chk("c_status2", 32'(status), 32'h4);
      repeat (2) begin
         ttx_req = 1; ttx_sid = 2; trx_req = 1; trx_sid = 2;
         etx_req = 1; etx_sid = 2; erx_req = 1; erx_sid = 2;
         tick();
      end
      chk("c_drain_busy", 32'(status), 32'h4);
      ttx_req = 1; ttx_sid = 2; etx_req = 1; etx_sid = 2;
      exp_q.push_back(4'b0100);
      tick();
      chk("c_term2", 32'(term), 32'h4);
      chk("c_no_err", 32'(err), 0);
      tick();

      // underflow on idle slot
      ttx_req = 1; ttx_sid = 2;
      tick();
      chk("d_err", 32'(err), 1);
      chk("d_err_sid", 32'(err_sid), 2);
      chk("d_status", 32'(status), 0);
      erx_req = 1; erx_sid = 1;
      tick();
      chk("d_err_sid_hold", 32'(err_sid), 2);
      err_clr = 1;
      tick();
      chk("d_err_clr", 32'(err), 0);
      chk("d_err_sid_clr", 32'(err_sid), 0);

      // overflow: 126 then +2 exceeds 127
      tx(3, 63); rx(3, 63);
      tick();
      chk("d_ovf_ok", 32'(err), 0);
      chk("d_ovf_busy", 32'(status), 32'h8);
      tx(3, 2);
      tick();
      chk("d_ovf_err", 32'(err), 1);
      chk("d_ovf_sid", 32'(err_sid), 3);
      err_clr = 1; ttx_req = 1; ttx_sid = 0;
      tick();
      chk("d_err_wins", 32'(err), 1);
      err_clr = 1;
      tick();
      chk("d_err_clr2", 32'(err), 0);
      clr = 1; clr_sid = 3;
      tick();
      chk("d_clr_status", 32'(status), 0);
      tick();
      chk("d_clr_status2", 32'(status), 0);

      // clear beats same-cycle enqueue and release
      tx(1, 4);
      tick();
      chk("e_busy", 32'(status), 32'h2);
      clr = 1; clr_sid = 1; tx(1, 2); ttx_req = 1; ttx_sid = 1;
      tick();
      chk("e_status", 32'(status), 0);
      chk("e_term", 32'(term), 0);
      tick();
      chk("e_status2", 32'(status), 0);
      tx(1, 1);
      tick();
      ttx_req = 1; ttx_sid = 1; etx_req = 1; etx_sid = 1;
      exp_q.push_back(4'b0010);
      tick();
      chk("e_term_after", 32'(term), 32'h2);
      chk("e_no_err", 32'(err), 0);
      tick();

      // reset in the middle of a transfer
      ttx_req = 1; ttx_sid = 2;
      tick();
      chk("f_err_pre", 32'(err), 1);
      tx(0, 3);
      tick();
      ttx_req = 1; ttx_sid = 0;
      tick();
      chk("f_busy", 32'(status), 32'h1);
      rst_n = 0;
      #1;
      chk("f_rst_status", 32'(status), 0);
      chk("f_rst_term", 32'(term), 0);
      chk("f_rst_evt", 32'(evt), 0);
      chk("f_rst_err", 32'(err), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("f_post_status", 32'(status), 0);
      end

      tick();
      chk("queue_empty", 32'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
